// File: rtl/cve2_pkg.sv
// Shared types for the core-to-memory arbiter: requester ids, FSM states and
// the packed memory command that travels from a requester to the shared port.
package cve2_pkg;

    typedef enum logic {
        ARB_INSTR = 1'b0,
        ARB_DATA  = 1'b1
    } arb_id_e;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

    localparam logic [3:0] INSTR_BE = 4'hF;

    // Fetches are always full-word reads.
    function automatic mem_cmd_t instr_cmd(input logic [31:0] addr);
        mem_cmd_t cmd;
        cmd.we    = 1'b0;
        cmd.be    = INSTR_BE;
        cmd.addr  = addr;
        cmd.wdata = '0;
        return cmd;
    endfunction

endpackage

// File: rtl/cve2_arb_id_fifo.sv
// In-order FIFO of requester ids for granted-but-unanswered memory transactions.
// The head is read combinationally so responses can be steered with zero latency.
module cve2_arb_id_fifo
    import cve2_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         push_i,
    input  arb_id_e                      push_id_i,
    input  logic                         pop_i,
    output arb_id_e                      head_id_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    arb_id_e         id_mem [Depth];
    logic [PtrW-1:0] wr_ptr_reg;
    logic [PtrW-1:0] rd_ptr_reg;
    logic [CntW-1:0] count_reg;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty_o   = (count_reg == '0);
    assign full_o    = (count_reg == CntW'(Depth));
    assign count_o   = count_reg;
    assign head_id_o = id_mem[rd_ptr_reg];

    // A pop frees a slot in the same cycle, so push-while-full is legal then.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            id_mem[wr_ptr_reg] <= push_id_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/cve2_mem_arbiter.sv
// Round-robin arbiter sharing one OBI-style memory port between the core's
// instruction fetch and load/store ports, with in-order response steering.
module cve2_mem_arbiter
    import cve2_pkg::*;
#(
    parameter int MaxOutstanding = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,

    input  logic                                  instr_req_i,
    input  logic [31:0]                           instr_addr_i,
    output logic                                  instr_gnt_o,
    output logic                                  instr_rvalid_o,
    output logic [31:0]                           instr_rdata_o,
    output logic                                  instr_err_o,

    input  logic                                  data_req_i,
    input  logic                                  data_we_i,
    input  logic [3:0]                            data_be_i,
    input  logic [31:0]                           data_addr_i,
    input  logic [31:0]                           data_wdata_i,
    output logic                                  data_gnt_o,
    output logic                                  data_rvalid_o,
    output logic [31:0]                           data_rdata_o,
    output logic                                  data_err_o,

    output logic                                  mem_req_o,
    output logic                                  mem_we_o,
    output logic [3:0]                            mem_be_o,
    output logic [31:0]                           mem_addr_o,
    output logic [31:0]                           mem_wdata_o,
    input  logic                                  mem_gnt_i,
    input  logic                                  mem_rvalid_i,
    input  logic [31:0]                           mem_rdata_i,
    input  logic                                  mem_err_i,

    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
    output logic                                  rsp_unexpected_o
);

    arb_state_e state_reg;
    arb_state_e state_next;
    arb_id_e    winner_reg;
    arb_id_e    winner;
    logic       prefer_data_reg;
    logic       prefer_data_next;
    mem_cmd_t   hold_cmd_reg;
    mem_cmd_t   hold_cmd_next;
    mem_cmd_t   instr_c;
    mem_cmd_t   data_c;
    mem_cmd_t   cmd;
    logic       req_valid;
    logic       handshake;

    logic       fifo_full;
    logic       fifo_empty;
    arb_id_e    head_id;
    logic       rsp_live;
    logic       rsp_pop;

    assign instr_c = instr_cmd(instr_addr_i);

    always_comb begin
        data_c.we    = data_we_i;
        data_c.be    = data_be_i;
        data_c.addr  = data_addr_i;
        data_c.wdata = data_wdata_i;
    end

    always_comb begin
        state_next       = state_reg;
        winner           = winner_reg;
        prefer_data_next = prefer_data_reg;
        hold_cmd_next    = hold_cmd_reg;
        cmd              = hold_cmd_reg;
        req_valid        = 1'b0;

        case (state_reg)
            ARB: begin
                // At the outstanding limit nothing is offered, even if a
                // response is arriving this very cycle.
                if (!fifo_full && (instr_req_i || data_req_i)) begin
                    req_valid = 1'b1;
                    if (instr_req_i && data_req_i) begin
                        winner = prefer_data_reg ? ARB_DATA : ARB_INSTR;
                    end else begin
                        winner = data_req_i ? ARB_DATA : ARB_INSTR;
                    end
                    cmd = (winner == ARB_DATA) ? data_c : instr_c;
                    if (!mem_gnt_i) begin
                        state_next    = HOLD;
                        hold_cmd_next = cmd;
                    end
                end
            end
            HOLD: begin
                req_valid = 1'b1;
                if (mem_gnt_i) begin
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase

        if (rst_i) begin
            req_valid = 1'b0;
        end

        handshake = req_valid && mem_gnt_i;
        if (handshake) begin
            prefer_data_next = (winner == ARB_INSTR);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg       <= ARB;
            winner_reg      <= ARB_DATA;
            prefer_data_reg <= 1'b1;
            hold_cmd_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            winner_reg      <= winner;
            prefer_data_reg <= prefer_data_next;
            hold_cmd_reg    <= hold_cmd_next;
        end
    end

    assign mem_req_o = req_valid;
    assign {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} = req_valid ? cmd : '0;

    assign instr_gnt_o = handshake && (winner == ARB_INSTR);
    assign data_gnt_o  = handshake && (winner == ARB_DATA);

    cve2_arb_id_fifo #(
        .Depth     (MaxOutstanding)
    ) u_id_fifo (
        .clk       (clk_i),
        .srst      (rst_i),
        .push_i    (handshake),
        .push_id_i (winner),
        .pop_i     (rsp_pop),
        .head_id_o (head_id),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (outstanding_o)
    );

    // Responses with nothing outstanding are dropped and flagged.
    assign rsp_live         = mem_rvalid_i && !rst_i;
    assign rsp_pop          = rsp_live && !fifo_empty;
    assign rsp_unexpected_o = rsp_live && fifo_empty;

    assign instr_rvalid_o = rsp_pop && (head_id == ARB_INSTR);
    assign data_rvalid_o  = rsp_pop && (head_id == ARB_DATA);
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
    assign instr_err_o    = instr_rvalid_o && mem_err_i;
    assign data_err_o     = data_rvalid_o && mem_err_i;

endmodule

// File: tb/tb_cve2_mem_arbiter.sv
// Directed bench for cve2_mem_arbiter: stimulus queues expected grants and
// responses, a negedge monitor pops and compares whenever the DUT presents one.
module tb_cve2_mem_arbiter;
    import cve2_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;
    logic [1:0]  outstanding_o;
    logic        rsp_unexpected_o;

    always #5 clk_i = ~clk_i;

    cve2_mem_arbiter #(.MaxOutstanding(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .outstanding_o(outstanding_o), .rsp_unexpected_o(rsp_unexpected_o)
    );

    // kind: 0 = instr, 1 = data, 2 = unexpected
    typedef struct {
        int          id;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_exp_t;

    typedef struct {
        int          kind;
        logic [31:0] rdata;
        logic        err;
    } rsp_exp_t;

    gnt_exp_t gnt_q[$];
    rsp_exp_t rsp_q[$];
    gnt_exp_t g;
    rsp_exp_t r;
    logic [2:0] rsp_vec;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_gnt(input int id, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        gnt_exp_t e;
        e.id = id; e.we = we; e.be = be; e.addr = addr; e.wdata = wdata;
        gnt_q.push_back(e);
    endtask

    task automatic exp_rsp(input int kind, input logic [31:0] rdata, input logic err);
        rsp_exp_t e;
        e.kind = kind; e.rdata = rdata; e.err = err;
        rsp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk_i);
            if (instr_gnt_o || data_gnt_o) begin
                if (gnt_q.size() == 0) begin
                    check("spurious_gnt", {30'b0, data_gnt_o, instr_gnt_o}, 32'd0);
                end else begin
                    g = gnt_q.pop_front();
                    check("gnt_id", {30'b0, data_gnt_o, instr_gnt_o}, (g.id == 1) ? 32'd2 : 32'd1);
                    check("gnt_we", mem_we_o, g.we);
                    check("gnt_be", mem_be_o, g.be);
                    check("gnt_addr", mem_addr_o, g.addr);
                    check("gnt_wdata", mem_wdata_o, g.wdata);
                    $display("grant %s addr=0x%08h we=%0b be=0x%h", data_gnt_o ? "data " : "instr",
                             mem_addr_o, mem_we_o, mem_be_o);
                end
            end
            rsp_vec = {rsp_unexpected_o, data_rvalid_o, instr_rvalid_o};
            if (rsp_vec != 3'b000) begin
                if (rsp_q.size() == 0) begin
                    check("spurious_rsp", rsp_vec, 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_route", rsp_vec, (r.kind == 0) ? 32'd1 : (r.kind == 1) ? 32'd2 : 32'd4);
                    if (r.kind == 0) begin
                        check("rsp_instr_rdata", instr_rdata_o, r.rdata);
                        check("rsp_instr_err", instr_err_o, r.err);
                    end else if (r.kind == 1) begin
                        check("rsp_data_rdata", data_rdata_o, r.rdata);
                        check("rsp_data_err", data_err_o, r.err);
                    end
                    $display("response vec=%03b rdata=0x%08h err=%0b", rsp_vec, mem_rdata_i, mem_err_i);
                end
            end
            if (!instr_rvalid_o) begin
                check("instr_idle_rdata", {instr_err_o, instr_rdata_o[30:0]} | instr_rdata_o, 32'd0);
            end
            if (!data_rvalid_o) begin
                check("data_idle_rdata", {data_err_o, data_rdata_o[30:0]} | data_rdata_o, 32'd0);
            end
        end
    end

    // Stimulus
    initial begin
        rst_i = 1'b1;
        instr_req_i = 1'b0; instr_addr_i = '0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
        tick();
        @(negedge clk_i);
        check("rst_mem_req", mem_req_o, 32'd0);
        check("rst_outstanding", outstanding_o, 32'd0);
        check("rst_unexpected", rsp_unexpected_o, 32'd0);
        tick();
        rst_i = 1'b0;

        // C0: tie after reset, data first
        instr_req_i = 1'b1; instr_addr_i = 32'h100;
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'h3; data_addr_i = 32'h200; data_wdata_i = 32'h1234;
        mem_gnt_i = 1'b1;
        exp_gnt(1, 1'b1, 4'h3, 32'h200, 32'h1234);
        exp_gnt(0, 1'b0, 4'hF, 32'h100, 32'h0);
        tick();
        // C1
        data_req_i = 1'b0;
        tick();
        // C2: at limit, new fetch waits
        instr_addr_i = 32'h104;
        @(negedge clk_i);
        check("limit_mem_req", mem_req_o, 32'd0);
        check("limit_outstanding", outstanding_o, 32'd2);
        check("limit_instr_gnt", instr_gnt_o, 32'd0);
        tick();
        // C3: response N, no bypass
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA0001;
        exp_rsp(1, 32'hAAAA0001, 1'b0);
        @(negedge clk_i);
        check("no_bypass_mem_req", mem_req_o, 32'd0);
        tick();
        // C4: N+1, request issued, push + pop
        mem_rdata_i = 32'hBBBB0002;
        exp_rsp(0, 32'hBBBB0002, 1'b0);
        exp_gnt(0, 1'b0, 4'hF, 32'h104, 32'h0);
        @(negedge clk_i);
        check("after_rsp_mem_req", mem_req_o, 32'd1);
        tick();
        // C5
        instr_req_i = 1'b0;
        mem_rdata_i = 32'hDEAD0003; mem_err_i = 1'b1;
        exp_rsp(0, 32'hDEAD0003, 1'b1);
        @(negedge clk_i);
        check("pushpop_outstanding", outstanding_o, 32'd1);
        tick();
        // C6: stray response
        mem_err_i = 1'b0; mem_rdata_i = 32'h5555;
        exp_rsp(2, 32'h0, 1'b0);
        @(negedge clk_i);
        check("stray_outstanding", outstanding_o, 32'd0);
        tick();
        // C7: data held without grant
        mem_rvalid_i = 1'b0;
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h300; data_wdata_i = 32'h0;
        mem_gnt_i = 1'b0;
        @(negedge clk_i);
        check("unexp_one_cycle", rsp_unexpected_o, 32'd0);
        check("hold_mem_req", mem_req_o, 32'd1);
        check("hold_addr_c0", mem_addr_o, 32'h300);
        tick();
        // C8, C9: instr arrives while data locked
        instr_req_i = 1'b1; instr_addr_i = 32'h108;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            check("hold_addr", mem_addr_o, 32'h300);
            check("hold_instr_gnt", instr_gnt_o, 32'd0);
            check("hold_req", mem_req_o, 32'd1);
            tick();
        end
        // C10
        mem_gnt_i = 1'b1;
        exp_gnt(1, 1'b0, 4'hF, 32'h300, 32'h0);
        tick();
        // C11
        data_req_i = 1'b0;
        exp_gnt(0, 1'b0, 4'hF, 32'h108, 32'h0);
        tick();
        // C12
        instr_req_i = 1'b0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11;
        exp_rsp(1, 32'h11, 1'b0);
        @(negedge clk_i);
        check("full_again_outstanding", outstanding_o, 32'd2);
        tick();
        // C13: grant + error response at count 1, with a round-robin tie
        mem_rdata_i = 32'h22; mem_err_i = 1'b1;
        exp_rsp(0, 32'h22, 1'b1);
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hC; data_addr_i = 32'h400; data_wdata_i = 32'hCAFE;
        instr_req_i = 1'b1; instr_addr_i = 32'h10C;
        mem_gnt_i = 1'b1;
        exp_gnt(1, 1'b1, 4'hC, 32'h400, 32'hCAFE);
        @(negedge clk_i);
        check("rr_instr_waits", instr_gnt_o, 32'd0);
        tick();
        // C14
        data_req_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
        exp_gnt(0, 1'b0, 4'hF, 32'h10C, 32'h0);
        @(negedge clk_i);
        check("same_cycle_outstanding", outstanding_o, 32'd1);
        tick();
        // C15: reset with two outstanding
        instr_req_i = 1'b0; mem_gnt_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("pre_reset_outstanding", outstanding_o, 32'd2);
        check("in_reset_mem_req", mem_req_o, 32'd0);
        tick();
        // C16
        rst_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77;
        exp_rsp(2, 32'h0, 1'b0);
        @(negedge clk_i);
        check("post_reset_outstanding", outstanding_o, 32'd0);
        tick();
        // C17
        mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        check("post_reset_unexp_clear", rsp_unexpected_o, 32'd0);
        tick();
        tick();
        check("gnt_queue_drained", gnt_q.size(), 32'd0);
        check("rsp_queue_drained", rsp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cve2_mem_arbiter.md
CVE2_MEM_ARBITER -- requirements
Module: cve2_mem_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2, range 1..8: maximum granted-but-unanswered transactions.
REQ-002 SHALL have port clk_i  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_i  in  1  reset; synchronous and active-high.
REQ-004 SHALL have ports instr_req_i in 1, instr_addr_i in 32, instr_gnt_o out 1, instr_rvalid_o out 1, instr_rdata_o out 32, instr_err_o out 1  core fetch port (OBI-style).
REQ-005 SHALL have ports data_req_i in 1, data_we_i in 1, data_be_i in 4, data_addr_i in 32, data_wdata_i in 32, data_gnt_o out 1, data_rvalid_o out 1, data_rdata_o out 32, data_err_o out 1  core load/store port.
REQ-006 SHALL have ports mem_req_o out 1, mem_we_o out 1, mem_be_o out 4, mem_addr_o out 32, mem_wdata_o out 32, mem_gnt_i in 1, mem_rvalid_i in 1, mem_rdata_i in 32, mem_err_i in 1  shared memory port.
REQ-007 SHALL have port outstanding_o  out  $clog2(MaxOutstanding+1)  registered count of outstanding transactions.
REQ-008 SHALL have port rsp_unexpected_o  out  1  one-cycle pulse when mem_rvalid_i arrives with count 0.

Function
REQ-009 SHALL implement FSM states ARB and HOLD; ARB: no ungranted request on mem port; HOLD: mem_req_o asserted, winner locked.
REQ-010 In ARB, if count < MaxOutstanding and any request is pending, SHALL pick a winner by round-robin: the requester not granted last wins on a tie; after reset data wins the first tie.
REQ-011 In ARB with count == MaxOutstanding, SHALL hold mem_req_o low (no same-cycle bypass from mem_rvalid_i).
REQ-012 In ARB, a winner with mem_gnt_i high SHALL complete in the same cycle and the FSM SHALL stay in ARB; with mem_gnt_i low the FSM SHALL move to HOLD.
REQ-013 In HOLD, SHALL keep mem_req_o high with the locked winner's fields stable until mem_gnt_i, then return to ARB; the other requester SHALL NOT be granted meanwhile.
REQ-014 SHALL drive mem_* fields from the winner; for instr: mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
REQ-015 SHALL route mem_gnt_i combinationally to the winner's gnt_o only; the loser's gnt_o SHALL be 0.
REQ-016 On each handshake (mem_req_o & mem_gnt_i), SHALL push the winner id into an in-order id FIFO of depth MaxOutstanding.
REQ-017 On mem_rvalid_i with count > 0, SHALL pop the FIFO head and route rvalid/rdata/err combinationally (zero latency) to that requester; the other rvalid_o SHALL be 0.
REQ-018 On mem_rvalid_i with count == 0, SHALL drop the response, assert no rvalid_o, and pulse rsp_unexpected_o for one cycle.
REQ-019 On simultaneous push and pop, count SHALL stay unchanged and the FIFO ordering SHALL be preserved.
REQ-020 rdata_o/err_o SHALL be 0 whenever the matching rvalid_o is 0.
REQ-021 A handshake and a same-id response in the same cycle SHALL both be legal; the response belongs to the older entry.

Reset
REQ-022 While rst_i is high at a clock edge, SHALL clear the FSM to ARB, clear count and FIFO pointers, and set the round-robin pointer to data-first.
REQ-023 During and after reset, mem_req_o, all gnt_o/rvalid_o and rsp_unexpected_o SHALL be 0 until a new request arrives; outstanding_o SHALL read 0.
REQ-024 Reset mid-transaction SHALL abandon all outstanding ids; later stray responses SHALL follow REQ-018.

Structure
REQ-025 cve2_pkg SHALL hold typedef arb_id_e (ARB_INSTR=0, ARB_DATA=1) and typedef arb_state_e (ARB, HOLD).
REQ-026 The id FIFO SHALL be a sub-module cve2_arb_id_fifo (parameter Depth, synchronous active-high reset, push/pop/full/empty/count).

Verification
REQ-027 Instr and data request together after reset, mem_gnt_i=1 -> data granted cycle 0, instr cycle 1; responses 0xAAAA0001 then 0xBBBB0002 route to data then instr.
REQ-028 data_req_i held, mem_gnt_i low for 3 cycles, instr_req_i rises in cycle 1 -> mem_addr_o stays data address, instr_gnt_o=0 until data granted.
REQ-029 MaxOutstanding=2, two grants with no rvalid -> mem_req_o low, outstanding_o=2; rvalid in cycle N -> mem_req_o high earliest in cycle N+1.
REQ-030 mem_rvalid_i with count 0 -> rsp_unexpected_o=1 for one cycle, instr_rvalid_o=data_rvalid_o=0.
REQ-031 rst_i pulsed with 2 outstanding -> outstanding_o=0 next cycle; following rvalid flagged unexpected.
REQ-032 Grant and rvalid in the same cycle at count 1 -> outstanding_o stays 1; error response (mem_err_i=1) reaches the older requester's err_o.
